mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mips_pkg.sv | 22 ++
 rtl/mem_timeout_ctr.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- shared state encoding and default sizes for the memory-stage
// access controller (mem_access_ctrl) and its timeout counter.
package mips_pkg;

   // Access FSM: wait for an access, hold the bus request, one-cycle retire.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   localparam int DATA_WIDTH          = 32;
   localparam int MEM_TIMEOUT_DEFAULT = 16;
   // MEM_TIMEOUT is at most 255, so an 8-bit counter always suffices.
   localparam int TMO_CNT_W           = 8;

   // Word accesses only: the two byte-offset bits must be zero.
   function automatic logic word_aligned(input logic [1:0] lsbs);
      return (lsbs == 2'b00);
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr -- counts consecutive cycles spent in REQ and flags the
// last allowed one. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(MEM_TIMEOUT - 1);

   logic [TMO_CNT_W-1:0] count_q, count_d;

   // The count is zero in the first REQ cycle, so LAST marks the MEM_TIMEOUT-th.
   assign expired_o = en_i && (count_q == LAST);

   // Restart from zero whenever the FSM is outside REQ or is about to leave it.
   always_comb begin
      count_d = count_q;
      if (!en_i || expired_o) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- memory-stage load/store controller. Issues one registered
// request per aligned access, stalls the pipeline until completion and retires
// through a single DONE cycle so a still-present instruction is not re-issued.
// Optional bus timeout: define MEM_TIMEOUT_EN to abort REQ after MEM_TIMEOUT
// cycles and pulse bus_err_m; without it bus_err_m is tied low.
module mem_access_ctrl
   import mips_pkg::*;
#(
   parameter int data_width  = DATA_WIDTH,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem2reg_m,
   input  logic                  mem_write_m,
   input  logic [data_width-1:0] alu_result_m,
   input  logic [data_width-1:0] write_data_m,
   input  logic [data_width-1:0] mem_rdata,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [data_width-1:0] mem_addr,
   output logic [data_width-1:0] mem_wdata,
   output logic                  stall_m,
   output logic [data_width-1:0] load_data_m,
   output logic                  misalign_err_m,
   output logic                  bus_err_m
);

   if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_access_ctrl: MEM_TIMEOUT must lie in 2..255");
   end

   mem_state_e            state_q, state_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic                  is_load_q, is_load_d;
   logic                  misalign_q, misalign_d;
   logic [data_width-1:0] addr_q, addr_d;
   logic [data_width-1:0] wdata_q, wdata_d;
   logic [data_width-1:0] load_q, load_d;

   logic access;
   logic aligned;

   assign access  = mem2reg_m | mem_write_m;
   assign aligned = word_aligned(alu_result_m[1:0]);

`ifdef MEM_TIMEOUT_EN
   logic tmo_expired;
   logic bus_err_q, bus_err_d;

   mem_timeout_ctr #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_tmo (
      .clk_i     (clk),
      .rst_ni    (reset),
      .en_i      (state_q == REQ),
      .expired_o (tmo_expired)
   );

   assign bus_err_m = bus_err_q;
`else
   assign bus_err_m = 1'b0;
`endif

   assign mem_req        = req_q;
   assign mem_we         = we_q;
   assign mem_addr       = addr_q;
   assign mem_wdata      = wdata_q;
   assign load_data_m    = load_q;
   assign misalign_err_m = misalign_q;

   // Next-state, bus register updates and the combinational stall.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      is_load_d  = is_load_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      load_d     = load_q;
      misalign_d = 1'b0;
      stall_m    = 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus_err_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (access) begin
               if (aligned) begin
                  stall_m   = 1'b1;
                  state_d   = REQ;
                  req_d     = 1'b1;
                  we_d      = mem_write_m;
                  // A store wins over a simultaneous load: nothing is captured.
                  is_load_d = mem2reg_m & ~mem_write_m;
                  addr_d    = alu_result_m;
                  wdata_d   = write_data_m;
               end else begin
                  misalign_d = 1'b1;
               end
            end
         end
         REQ: begin
            stall_m = 1'b1;
            if (mem_ready) begin
               state_d = DONE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               if (is_load_q) begin
                  load_d = mem_rdata;
               end
`ifdef MEM_TIMEOUT_EN
            end else if (tmo_expired) begin
               state_d   = DONE;
               req_d     = 1'b0;
               we_d      = 1'b0;
               bus_err_d = 1'b1;
               if (is_load_q) begin
                  load_d = '0;
               end
`endif
            end
         end
         // Retire cycle: the pipeline advances, the old instruction is ignored.
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, bus and result registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         is_load_q  <= 1'b0;
         misalign_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         load_q     <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         is_load_q  <= is_load_d;
         misalign_q <= misalign_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         load_q     <= load_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // Bus-error pulse, high during the DONE cycle that follows a timeout.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_err_q <= 1'b0;
      end else begin
         bus_err_q <= bus_err_d;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl -- directed and randomized bench for mem_access_ctrl.
// Expected behaviour is derived per transaction from the access rules: an
// aligned access stalls for one presentation cycle plus every REQ cycle,
// retires in one DONE cycle, and only a completed load changes load_data_m.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

   localparam int W   = 32;
   localparam int TMO = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         mem2reg_m, mem_write_m, mem_ready;
   logic [W-1:0] alu_result_m, write_data_m, mem_rdata;
   logic         mem_req, mem_we, stall_m, misalign_err_m, bus_err_m;
   logic [W-1:0] mem_addr, mem_wdata, load_data_m;

   int           total = 0;
   int           bad   = 0;
   bit           tmo_en;
   logic [W-1:0] ld_model;   // value of the most recent completed load

   always #5 clk = ~clk;

   mem_access_ctrl #(
      .data_width  (W),
      .MEM_TIMEOUT (TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mem2reg_m      (mem2reg_m),
      .mem_write_m    (mem_write_m),
      .alu_result_m   (alu_result_m),
      .write_data_m   (write_data_m),
      .mem_rdata      (mem_rdata),
      .mem_ready      (mem_ready),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .stall_m        (stall_m),
      .load_data_m    (load_data_m),
      .misalign_err_m (misalign_err_m),
      .bus_err_m      (bus_err_m)
   );

   task automatic check(input string tag, input string what, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s/%s observed=%h expected=%h", tag, what, obs, exp);
      end
   endtask

   // Present one access at +3ns after a posedge; lat = REQ cycles with
   // mem_ready low before it rises. Returns at +3ns after a posedge.
   task automatic run_access(input string tag, input bit ld, input bit st,
                             input logic [W-1:0] addr, input logic [W-1:0] wdata,
                             input logic [W-1:0] rdata, input int lat);
      bit           aligned   = (addr[1:0] == 2'b00);
      bit           timed_out = tmo_en && (lat >= TMO);
      int           n_req     = timed_out ? TMO : lat + 1;
      int           stalls    = 0;
      logic [W-1:0] ld_before = ld_model;

      mem2reg_m    = ld;
      mem_write_m  = st;
      alu_result_m = addr;
      write_data_m = wdata;
      mem_ready    = 1'b1;            // no request yet: must be ignored
      mem_rdata    = $urandom;
      #2;
      check(tag, "pres_req", mem_req, 0);
      if (aligned) begin
         check(tag, "pres_stall", stall_m, 1);
         stalls += int'(stall_m);
      end
      @(posedge clk); #1;

      if (!aligned) begin
         mem2reg_m   = 1'b0;
         mem_write_m = 1'b0;
         mem_ready   = 1'b0;
         #2;
         check(tag, "misalign_pulse", misalign_err_m, 1);
         check(tag, "misalign_noreq", mem_req, 0);
         check(tag, "misalign_stall", stall_m, 0);
         check(tag, "misalign_ld", load_data_m, ld_model);
         @(posedge clk); #3;
         check(tag, "misalign_end", misalign_err_m, 0);
         check(tag, "misalign_noreq2", mem_req, 0);
         return;
      end

      for (int k = 1; k <= n_req; k++) begin
         mem_ready = (k == lat + 1);
         mem_rdata = mem_ready ? rdata : W'($urandom);
         #2;
         check(tag, "req", mem_req, 1);
         check(tag, "we", mem_we, st);
         check(tag, "addr", mem_addr, addr);
         check(tag, "wdata", mem_wdata, wdata);
         check(tag, "req_stall", stall_m, 1);
         check(tag, "req_ld_hold", load_data_m, ld_before);
         stalls += int'(stall_m);
         @(posedge clk); #1;
      end

      // DONE: the instruction is still presented and must not be re-issued.
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (ld && !st) ld_model = timed_out ? '0 : rdata;
      #2;
      check(tag, "done_req", mem_req, 0);
      check(tag, "done_we", mem_we, 0);
      check(tag, "done_stall", stall_m, 0);
      check(tag, "done_ld", load_data_m, ld_model);
      check(tag, "done_buserr", bus_err_m, timed_out);
      check(tag, "done_misalign", misalign_err_m, 0);
      stalls += int'(stall_m);
      check(tag, "stall_cycles", stalls, 1 + n_req);
      @(posedge clk); #1;

      mem2reg_m   = 1'b0;
      mem_write_m = 1'b0;
      mem_ready   = 1'b0;
      #2;
      check(tag, "no_reissue", mem_req, 0);
      check(tag, "after_buserr", bus_err_m, 0);
      check(tag, "after_ld", load_data_m, ld_model);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] a;
      int           kind;

      tmo_en = 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_en = 1'b1;
`endif
      reset        = 1'b0;
      mem2reg_m    = 1'b0;
      mem_write_m  = 1'b0;
      mem_ready    = 1'b0;
      alu_result_m = '0;
      write_data_m = '0;
      mem_rdata    = '0;
      ld_model     = '0;

      // Reset values, before any clock edge.
      #2;
      check("reset", "req", mem_req, 0);
      check("reset", "we", mem_we, 0);
      check("reset", "addr", mem_addr, 0);
      check("reset", "wdata", mem_wdata, 0);
      check("reset", "ld", load_data_m, 0);
      check("reset", "misalign", misalign_err_m, 0);
      check("reset", "buserr", bus_err_m, 0);
      check("reset", "stall", stall_m, 0);
      @(posedge clk);
      @(posedge clk); #3;
      reset = 1'b1;

      // Directed cases.
      run_access("load100", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
      run_access("store104", 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'hCAFE_F00D, 3);
      run_access("misalign102", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h1111_1111, 0);
      run_access("both", 1'b1, 1'b1, 32'h0000_0208, 32'hA5A5_5A5A, 32'h7777_7777, 1);
      run_access("store_mis", 1'b0, 1'b1, 32'h0000_0301, 32'h5555_AAAA, 32'h0, 0);
`ifdef MEM_TIMEOUT_EN
      run_access("timeout", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'hBAD0_BAD0, 100);
`endif

      // Randomized accesses.
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         kind = $urandom_range(1, 3);
         run_access("rand", kind[0], kind[1], a, W'($urandom), W'($urandom),
                    $urandom_range(0, 5));
      end

      // Reset in the middle of REQ, then re-issue the same load.
      mem2reg_m    = 1'b1;
      mem_write_m  = 1'b0;
      alu_result_m = 32'h0000_0400;
      write_data_m = '0;
      mem_ready    = 1'b0;
      @(posedge clk); #1;
      #2;
      check("midreset", "req_before", mem_req, 1);
      reset = 1'b0;
      #1;
      check("midreset", "req", mem_req, 0);
      check("midreset", "addr", mem_addr, 0);
      check("midreset", "ld", load_data_m, 0);
      check("midreset", "buserr", bus_err_m, 0);
      check("midreset", "misalign", misalign_err_m, 0);
      ld_model = '0;
      @(posedge clk); #1;
      mem_ready = 1'b1;
      #2;
      check("midreset", "held", mem_req, 0);
      reset = 1'b1;
      run_access("reissue", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_CAFE, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
